// File: rtl/sample_burst_gen_if.sv
// Sample stream handshake: a source drives valid/data, the sink drives ready.
interface sample_burst_gen_if #(
  parameter int DATA_W = 16
);
  logic              sample_valid;
  logic              sample_ready;
  logic [DATA_W-1:0] sample_data;

  modport master (
    output sample_valid,
    output sample_data,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  sample_data,
    output sample_ready
  );
endinterface

// File: rtl/sample_burst_gen.sv
// Burst sample transmitter: NUM_SAMPLES words per start,
// spaced by GAP_CYCLES idle cycles, one count_up per accepted word.
module sample_burst_gen #(
  parameter int NUM_SAMPLES = 1000,
  parameter int GAP_CYCLES  = 3,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] start_value,
  input  logic [DATA_W-1:0] step,
  sample_burst_gen_if.master smp,
  output logic              count_up,
  output logic              busy,
  output logic              burst_done
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] step_q, step_d;
  logic [9:0]        rem_q, rem_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              valid_q, busy_q, done_q;
  logic              hs;

  assign hs       = valid_q & smp.sample_ready;
  assign count_up = hs;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    step_d  = step_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d = S_SEND;
            data_d  = start_value;
            step_d  = step;
            rem_d   = 10'(NUM_SAMPLES);
          end
        end
        S_SEND: begin
          if (hs) begin
            rem_d  = rem_q - 10'd1;
            data_d = data_q + step_q;
            if (rem_q == 10'd1) begin
              state_d = S_DONE;
            end else if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              gap_d   = GW'(GAP_CYCLES);
            end
          end
        end
        S_GAP: begin
          // gap_q counts the idle cycles still to spend here
          if (gap_q <= GW'(1)) begin
            state_d = S_SEND;
            gap_d   = '0;
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      step_q  <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      valid_q <= (state_d == S_SEND);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign smp.sample_valid = valid_q;
  assign smp.sample_data  = data_q;
  assign busy             = busy_q;
  assign burst_done       = done_q;

endmodule

// File: tb/tb_sample_burst_gen.sv
// Random/directed bench for sample_burst_gen against a
// transaction-level model of the burst rules.
module tb_sample_burst_gen;

  localparam int N   = 1000;
  localparam int GAP = 3;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] start_value = '0;
  logic [DW-1:0] step = '0;
  logic          count_up, busy, burst_done;

  sample_burst_gen_if #(.DATA_W(DW)) bus ();

  sample_burst_gen #(
    .NUM_SAMPLES(N),
    .GAP_CYCLES (GAP),
    .DATA_W     (DW)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .start      (start),
    .abort      (abort),
    .start_value(start_value),
    .step       (step),
    .smp        (bus.master),
    .count_up   (count_up),
    .busy       (busy),
    .burst_done (burst_done)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // model: burst in progress, sample count, wait cycles before next valid
  bit            m_active, m_done;
  int            m_n, m_wait;
  logic [DW-1:0] m_data, m_step;

  int            pulses, dones;
  logic [DW-1:0] acc_q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_n = 0; m_wait = 0;
    m_data = '0; m_step = '0;
  endtask

  task automatic model_edge();
    if ((m_active || m_done) && abort) begin
      m_active = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start && !abort) begin
        m_active = 1; m_n = 0; m_wait = 0;
        m_data = start_value; m_step = step;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (bus.sample_ready) begin
      m_n++;
      m_data = m_data + m_step;
      if (m_n == N) begin
        m_active = 0; m_done = 1;
      end else begin
        m_wait = GAP;
      end
    end
  endtask

  task automatic check_outs();
    bit ev;
    ev = m_active && (m_wait == 0);
    chk("valid", 32'(bus.sample_valid), 32'(ev));
    chk("data", 32'(bus.sample_data), 32'(m_data));
    chk("busy", 32'(busy), 32'(m_active || m_done));
    chk("done", 32'(burst_done), 32'(m_done));
    chk("count_up", 32'(count_up), 32'(ev && bus.sample_ready));
    if (count_up) begin
      pulses++;
      acc_q.push_back(bus.sample_data);
    end
    if (burst_done) dones++;
  endtask

  // inputs are set just after a falling edge; check, then clock once
  task automatic cyc();
    #1;
    if (!n_reset) model_reset();
    check_outs();
    @(posedge clk);
    if (n_reset) model_edge();
    @(negedge clk);
  endtask

  task automatic begin_burst(logic [DW-1:0] sv, logic [DW-1:0] st);
    pulses = 0; dones = 0; acc_q.delete();
    start_value = sv; step = st; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int guard;
    int bp;
    model_reset();
    bus.sample_ready = 1'b0;

    // 1: reset with random inputs
    @(negedge clk);
    repeat (6) begin
      start = 1'($urandom); abort = 1'($urandom);
      bus.sample_ready = 1'($urandom);
      start_value = 16'($urandom); step = 16'($urandom);
      cyc();
    end
    start = 0; abort = 0;
    n_reset = 1'b1;
    cyc();

    // 2+3: full burst with 5-cycle backpressure on sample 3
    bus.sample_ready = 1'b1;
    begin_burst(16'h0010, 16'h0001);
    #1;
    chk("first_valid", 32'(bus.sample_valid), 32'd1);
    chk("first_data", 32'(bus.sample_data), 32'h0010);
    bp = 5; guard = 0;
    while ((m_active || m_done) && guard < 6000) begin
      if (m_active && m_n == 2 && m_wait == 0 && bp > 0) begin
        bus.sample_ready = 1'b0; bp--;
        if (bp == 0) chk("bp_hold", 32'(bus.sample_data), 32'h0012);
      end else begin
        bus.sample_ready = 1'b1;
      end
      cyc(); guard++;
    end
    chk("burstA_timeout", 32'(guard < 6000), 32'd1);
    chk("burstA_pulses", 32'(pulses), 32'(N));
    chk("burstA_last", 32'(acc_q[acc_q.size()-1]), 32'h03F7);
    chk("burstA_s3", 32'(acc_q[2]), 32'h0012);
    chk("burstA_done", 32'(dones), 32'd1);
    cyc();
    chk("burstA_busy_after", 32'(busy), 32'd0);

    // 4: wrap checks
    begin_burst(16'hFFFE, 16'h0001);
    while (pulses < 4 && m_active) cyc();
    chk("wrap0", 32'(acc_q[0]), 32'hFFFE);
    chk("wrap1", 32'(acc_q[1]), 32'hFFFF);
    chk("wrap2", 32'(acc_q[2]), 32'h0000);
    chk("wrap3", 32'(acc_q[3]), 32'h0001);
    abort = 1'b1; cyc(); abort = 1'b0; cyc();
    begin_burst(16'h8000, 16'h8000);
    while (pulses < 2 && m_active) cyc();
    chk("wrapB0", 32'(acc_q[0]), 32'h8000);
    chk("wrapB1", 32'(acc_q[1]), 32'h0000);
    abort = 1'b1; cyc(); abort = 1'b0;

    // start and abort together in IDLE: stays idle
    start = 1'b1; abort = 1'b1; cyc();
    start = 1'b0; abort = 1'b0; cyc();
    chk("start_abort_idle", 32'(busy), 32'd0);

    // 5: random ready, abort after 500 accepted samples
    begin_burst(16'($urandom), 16'($urandom));
    guard = 0;
    while (m_n < 500 && guard < 20000) begin
      bus.sample_ready = ($urandom_range(0, 3) != 0);
      cyc(); guard++;
    end
    abort = 1'b1; bus.sample_ready = 1'b0;
    cyc();
    abort = 1'b0;
    #1;
    chk("abort_valid", 32'(bus.sample_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    cyc(); cyc();
    chk("abort_pulses", 32'(pulses), 32'd500);
    chk("abort_no_done", 32'(dones), 32'd0);

    // 6a: fresh burst, random ready, stray starts while busy
    begin_burst(16'($urandom), 16'($urandom));
    guard = 0;
    while ((m_active || m_done) && guard < 20000) begin
      bus.sample_ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 15) == 0);
      cyc(); guard++;
    end
    start = 1'b0;
    chk("burstC_timeout", 32'(guard < 20000), 32'd1);
    chk("burstC_pulses", 32'(pulses), 32'(N));
    chk("burstC_done", 32'(dones), 32'd1);
    cyc();

    // 6b: n_reset mid-GAP
    bus.sample_ready = 1'b1;
    begin_burst(16'h1234, 16'h0003);
    guard = 0;
    while (!(m_active && m_n > 3 && m_wait > 0) && guard < 100) begin
      cyc(); guard++;
    end
    #2 n_reset = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.sample_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(burst_done), 32'd0);
    chk("rst_cu", 32'(count_up), 32'd0);
    chk("rst_data", 32'(bus.sample_data), 32'd0);
    model_reset();
    @(negedge clk);
    n_reset = 1'b1;
    cyc();
    begin_burst(16'h0100, 16'h0002);
    guard = 0;
    while ((m_active || m_done) && guard < 6000) begin
      cyc(); guard++;
    end
    chk("burstD_pulses", 32'(pulses), 32'(N));
    chk("burstD_first", 32'(acc_q[0]), 32'h0100);
    chk("burstD_done", 32'(dones), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
